div_share_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared signed 32-bit iterative divider custom-instruction unit. It accepts divide requests from two masters, such as the Nios custom-instruction path and the ENET timing engine. It latches the operands of the granted request, pulses the divider's start and counts its fixed latency. It then captures the quotient and returns it with a one-cycle done strobe and a divide-by-zero flag. It sits between the requesters and the divider instance, and owns the divider's `start`, `dataa`, `datab` and `clk_en` pins exclusively.

---
 rtl/div_share_arbiter_pkg.sv | 7 +
 rtl/div_share_arbiter_if.sv | 19 +
 rtl/div_rr_picker.sv | 12 +
 rtl/div_share_arbiter.sv | 82 ++++++++
 tb/tb_div_share_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_share_arbiter_pkg.sv
// div_arb_pkg: FSM state type and shared constants for the divider-share arbiter.
package div_arb_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  localparam int DIV_CYCLES_DEFAULT = 33;
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
endpackage

// File: rtl/div_share_arbiter_if.sv
// div_share_arbiter_if: requester handshake and divider pins of the divider-share arbiter.
interface div_share_arbiter_if;
  logic req0, req1;
  logic [31:0] a0, b0, a1, b1;
  logic done0, done1;
  logic [31:0] result0, result1;
  logic dz0, dz1;
  logic busy;
  logic div_start, div_clk_en;
  logic [31:0] div_dataa, div_datab, div_result;
  modport slave (
    input req0, req1, a0, b0, a1, b1, div_result,
    output done0, done1, result0, result1, dz0, dz1, busy, div_start, div_clk_en, div_dataa, div_datab
  );
  modport master (
    output req0, req1, a0, b0, a1, b1, div_result,
    input done0, done1, result0, result1, dz0, dz1, busy, div_start, div_clk_en, div_dataa, div_datab
  );
endinterface

// File: rtl/div_rr_picker.sv
// div_rr_picker: two-way round-robin choice; on a tie the requester not served last wins.
module div_rr_picker (
  input  logic [1:0] elig,
  input  logic       last_gnt,
  output logic       gnt_valid,
  output logic       gnt_id
);
  always_comb begin
    gnt_valid = |elig;
    gnt_id = (&elig) ? ~last_gnt : elig[1];
  end
endmodule

// File: rtl/div_share_arbiter.sv
// div_share_arbiter: shares one iterative divider between two requesters,
// sequencing start, fixed latency wait and per-requester result capture.
module div_share_arbiter
  import div_arb_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT,
  parameter int CNT_W = 6
) (
  input logic clk,
  input logic reset,
  input logic clk_en,
  div_share_arbiter_if.slave bus
);
  state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic start_pend, gnt_id, last_gnt, pick_valid, pick_id;
  logic [31:0] op_a, op_b;
  logic [1:0] done, dz, elig;
  logic [1:0][31:0] result;
  // a requester still seeing its own done is not eligible, so it cannot re-win immediately
  assign elig = {bus.req1 & ~done[REQ1], bus.req0 & ~done[REQ0]};
  div_rr_picker picker (
    .elig(elig),
    .last_gnt(last_gnt),
    .gnt_valid(pick_valid),
    .gnt_id(pick_id)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = pick_valid ? RUN : IDLE;
      RUN:     nxt = (cnt == '0) ? FINISH : RUN;
      FINISH:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else if (clk_en) state <= nxt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      start_pend <= 1'b0;
      gnt_id <= REQ0;
      last_gnt <= REQ1;
      op_a <= '0;
      op_b <= '0;
      done <= '0;
      dz <= '0;
      result <= '0;
    end else if (clk_en) begin
      done <= '0;
      if (state == IDLE && pick_valid) begin
        op_a <= pick_id ? bus.a1 : bus.a0;
        op_b <= pick_id ? bus.b1 : bus.b0;
        gnt_id <= pick_id;
        cnt <= CNT_W'(DIV_CYCLES - 1);
        start_pend <= 1'b1;
      end
      if (state == RUN) begin
        start_pend <= 1'b0;
        cnt <= cnt - 1'b1;
      end
      if (state == FINISH) begin
        result[gnt_id] <= bus.div_result;
        dz[gnt_id] <= (op_b == '0);
        done[gnt_id] <= 1'b1;
        last_gnt <= gnt_id;
      end
    end
  assign bus.busy = (state != IDLE);
  assign bus.div_start = start_pend;
  assign bus.div_clk_en = clk_en;
  assign bus.div_dataa = op_a;
  assign bus.div_datab = op_b;
  assign bus.done0 = done[REQ0];
  assign bus.done1 = done[REQ1];
  assign bus.dz0 = dz[REQ0];
  assign bus.dz1 = dz[REQ1];
  assign bus.result0 = result[REQ0];
  assign bus.result1 = result[REQ1];
endmodule

// File: tb/tb_div_share_arbiter.sv
// tb_div_share_arbiter: directed scenarios against a fixed-latency divider model.
module tb_div_share_arbiter;
  import div_arb_pkg::*;
  localparam int DC = DIV_CYCLES_DEFAULT;
  logic clk = 1'b0, reset = 1'b1, clk_en = 1'b1;
  int checks = 0, passes = 0;
  div_share_arbiter_if bus ();
  div_share_arbiter #(.DIV_CYCLES(DC), .CNT_W(6)) dut (
    .clk(clk),
    .reset(reset),
    .clk_en(clk_en),
    .bus(bus)
  );
  always #5 clk = ~clk;
  // divider model: quotient valid only after DC enabled edges counted from the start edge
  logic [31:0] m_a = '0, m_b = '0;
  int m_cnt = 0;
  function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b);
    return (b == 0) ? 32'hFFFFFFFF : 32'($signed(a) / $signed(b));
  endfunction
  always @(posedge clk)
    if (bus.div_clk_en) begin
      if (bus.div_start) begin
        m_a <= bus.div_dataa;
        m_b <= bus.div_datab;
        m_cnt <= 1;
      end else if (m_cnt != 0 && m_cnt < DC) m_cnt <= m_cnt + 1;
    end
  assign bus.div_result = (m_cnt == DC) ? quot(m_a, m_b) : 32'hDEADBEEF;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                        output int n, output logic [31:0] res, output logic z);
    if (id) begin bus.a1 = a; bus.b1 = b; bus.req1 = 1'b1; end
    else begin bus.a0 = a; bus.b0 = b; bus.req0 = 1'b1; end
    n = 0;
    do begin tick(); n++; end while (!(id ? bus.done1 : bus.done0) && n < 200);
    res = id ? bus.result1 : bus.result0;
    z = id ? bus.dz1 : bus.dz0;
    if (id) bus.req1 = 1'b0; else bus.req0 = 1'b0;
    tick();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.busy, bus.div_start, bus.done0, bus.done1, bus.dz0, bus.dz1} !== 6'b0)
      $display("FAIL reset_flags: got %b want 000000", {bus.busy, bus.div_start, bus.done0, bus.done1, bus.dz0, bus.dz1});
    else passes++;
    checks++;
    if (bus.result0 !== 32'd0 || bus.result1 !== 32'd0)
      $display("FAIL reset_results: got %h %h want 0 0", bus.result0, bus.result1);
    else passes++;
    checks++;
    if (bus.div_dataa !== 32'd0 || bus.div_datab !== 32'd0)
      $display("FAIL reset_operands: got %h %h want 0 0", bus.div_dataa, bus.div_datab);
    else passes++;
    clk_en = 1'b0;
    #1;
    checks++;
    if (bus.div_clk_en !== 1'b0) $display("FAIL clk_en_passthru: got %b want 0", bus.div_clk_en);
    else passes++;
    clk_en = 1'b1;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int n, starts;
    logic d1;
    bus.a0 = 32'd100; bus.b0 = 32'd7; bus.req0 = 1'b1;
    tick();
    n = 1;
    bus.a0 = 32'd999;
    checks++;
    if (bus.div_start !== 1'b1 || bus.busy !== 1'b1 || bus.div_dataa !== 32'd100 || bus.div_datab !== 32'd7)
      $display("FAIL single_grant: start=%b busy=%b a=%0d b=%0d want 1 1 100 7", bus.div_start, bus.busy, bus.div_dataa, bus.div_datab);
    else passes++;
    starts = int'(bus.div_start);
    d1 = 1'b0;
    while (!bus.done0 && n < 200) begin
      tick();
      n++;
      starts += int'(bus.div_start);
      d1 |= bus.done1;
    end
    checks++;
    if (n !== 35) $display("FAIL single_latency: got %0d want 35", n); else passes++;
    checks++;
    if (bus.result0 !== 32'd14) $display("FAIL single_result: got %0d want 14", bus.result0); else passes++;
    checks++;
    if (bus.dz0 !== 1'b0) $display("FAIL single_dz: got %b want 0", bus.dz0); else passes++;
    checks++;
    if (starts !== 1) $display("FAIL single_start_count: got %0d want 1", starts); else passes++;
    checks++;
    if (d1 !== 1'b0) $display("FAIL single_no_done1: got %b want 0", d1); else passes++;
    bus.req0 = 1'b0;
    tick();
    checks++;
    if (bus.done0 !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL single_done_width: done0=%b busy=%b want 0 0", bus.done0, bus.busy);
    else passes++;
  endtask

  task automatic test_signed();
    int va[3] = '{-100, 100, -100};
    int vb[3] = '{7, -7, -7};
    int ve[3] = '{-14, -14, 14};
    int n;
    logic [31:0] res;
    logic z;
    for (int i = 0; i < 3; i++) begin
      run_op(1'b1, 32'(va[i]), 32'(vb[i]), n, res, z);
      checks++;
      if (n !== 35 || res !== 32'(ve[i]))
        $display("FAIL signed_%0d: got n=%0d res=%h want n=35 res=%h", i, n, res, 32'(ve[i]));
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    int who[5] = '{-1, -1, -1, -1, -1};
    int when[5] = '{0, 0, 0, 0, 0};
    int exp_who[5] = '{0, 1, 0, 1, 0};
    logic [31:0] val[5];
    int ev = 0, n = 0, drop_at = -1;
    pulse_reset();
    bus.a0 = 32'd60; bus.b0 = 32'd3; bus.a1 = 32'd25; bus.b1 = 32'd5;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    while (ev < 5 && n < 400) begin
      tick();
      n++;
      if (n == drop_at) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
      if (bus.done0 && ev < 5) begin who[ev] = 0; when[ev] = n; val[ev] = bus.result0; ev++; end
      if (bus.done1 && ev < 5) begin who[ev] = 1; when[ev] = n; val[ev] = bus.result1; ev++; end
      if (ev == 4 && drop_at < 0) drop_at = n + 1;
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (who[i] !== exp_who[i] || when[i] !== 35 * (i + 1))
        $display("FAIL b2b_event_%0d: got id=%0d cycle=%0d want id=%0d cycle=%0d", i, who[i], when[i], exp_who[i], 35 * (i + 1));
      else passes++;
    end
    checks++;
    if (val[0] !== 32'd20 || val[4] !== 32'd20)
      $display("FAIL b2b_result0: got %0d %0d want 20 20", val[0], val[4]);
    else passes++;
    checks++;
    if (val[1] !== 32'd5) $display("FAIL b2b_result1: got %0d want 5", val[1]); else passes++;
  endtask

  task automatic test_rr_tie();
    int n = 0, first = -1, t0 = 0, t1 = 0;
    logic [31:0] r0 = '0, r1 = '0;
    bus.a0 = 32'd8; bus.b0 = 32'd2; bus.a1 = 32'd9; bus.b1 = 32'd3;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    while (t0 == 0 && n < 300) begin
      tick();
      n++;
      if (bus.done1 && t1 == 0) begin t1 = n; if (first < 0) first = 1; r1 = bus.result1; bus.req1 = 1'b0; end
      if (bus.done0) begin t0 = n; if (first < 0) first = 0; r0 = bus.result0; bus.req0 = 1'b0; end
    end
    tick();
    checks++;
    if (first !== 1 || t1 !== 35) $display("FAIL rr_tie_first: got id=%0d cycle=%0d want id=1 cycle=35", first, t1);
    else passes++;
    checks++;
    if (r1 !== 32'd3) $display("FAIL rr_tie_result1: got %0d want 3", r1); else passes++;
    checks++;
    if (t0 !== 70) $display("FAIL rr_tie_second: got cycle=%0d want 70", t0); else passes++;
    checks++;
    if (r0 !== 32'd4) $display("FAIL rr_tie_result0: got %0d want 4", r0); else passes++;
  endtask

  task automatic test_div_zero();
    int n;
    logic [31:0] res;
    logic z;
    run_op(1'b0, 32'd5, 32'd0, n, res, z);
    checks++;
    if (n !== 35 || z !== 1'b1) $display("FAIL dz_flag: got n=%0d dz=%b want 35 1", n, z); else passes++;
    checks++;
    if (res !== 32'hFFFFFFFF) $display("FAIL dz_result: got %h want ffffffff", res); else passes++;
    run_op(1'b0, 32'd9, 32'd3, n, res, z);
    checks++;
    if (res !== 32'd3 || z !== 1'b0) $display("FAIL dz_clear: got res=%0d dz=%b want 3 0", res, z); else passes++;
  endtask

  task automatic test_clk_en();
    int n = 0;
    bus.a0 = 32'hFFFFFFCE; bus.b0 = 32'd5; bus.req0 = 1'b1;
    repeat (10) begin tick(); n++; end
    clk_en = 1'b0;
    repeat (10) begin tick(); n++; end
    checks++;
    if (bus.busy !== 1'b1 || bus.div_clk_en !== 1'b0 || bus.done0 !== 1'b0)
      $display("FAIL gate_frozen: busy=%b div_clk_en=%b done0=%b want 1 0 0", bus.busy, bus.div_clk_en, bus.done0);
    else passes++;
    clk_en = 1'b1;
    while (!bus.done0 && n < 200) begin tick(); n++; end
    checks++;
    if (n !== 45) $display("FAIL gate_latency: got %0d want 45", n); else passes++;
    checks++;
    if (bus.result0 !== 32'hFFFFFFF6) $display("FAIL gate_result: got %h want fffffff6", bus.result0); else passes++;
    clk_en = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.done0 !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL gate_done_hold: done0=%b busy=%b want 1 0", bus.done0, bus.busy);
    else passes++;
    clk_en = 1'b1;
    bus.req0 = 1'b0;
    tick();
    checks++;
    if (bus.done0 !== 1'b0) $display("FAIL gate_done_release: got %b want 0", bus.done0); else passes++;
  endtask

  task automatic test_reset_mid();
    int n;
    logic seen = 1'b0;
    logic [31:0] res;
    logic z;
    bus.a1 = 32'd77; bus.b1 = 32'd7; bus.req1 = 1'b1;
    repeat (16) tick();
    reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.div_start !== 1'b0 || bus.done1 !== 1'b0 || bus.result1 !== 32'd0 || bus.div_dataa !== 32'd0)
      $display("FAIL midreset_async: busy=%b start=%b done1=%b res1=%h a=%h want 0 0 0 0 0", bus.busy, bus.div_start, bus.done1, bus.result1, bus.div_dataa);
    else passes++;
    reset = 1'b0;
    bus.req1 = 1'b0;
    repeat (60) begin tick(); seen |= bus.done0 | bus.done1 | bus.busy; end
    checks++;
    if (seen !== 1'b0) $display("FAIL midreset_no_done: got %b want 0", seen); else passes++;
    run_op(1'b1, 32'd77, 32'd7, n, res, z);
    checks++;
    if (n !== 35 || res !== 32'd11 || z !== 1'b0)
      $display("FAIL midreset_recover: got n=%0d res=%0d dz=%b want 35 11 0", n, res, z);
    else passes++;
  endtask

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    test_reset();
    test_single();
    test_signed();
    test_back_to_back();
    test_rr_tie();
    test_div_zero();
    test_clk_en();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
